carregador_programa: RTL

CARREGADOR_PROGRAMA -- requirements
Module: carregador_programa

---
 rtl/nrisc_pkg.sv | 16 +
 rtl/memoria_instrucao.sv | 38 +++
 rtl/carregador_programa.sv | 93 +++++++++
 3 files changed

// File: rtl/nrisc_pkg.sv
// nrisc_pkg -- constants and types shared by the nRISC blocks.
//   LARG_DADO : width of an instruction / program-stream byte
//   LARG_END  : width of an instruction-memory address
//   estado_t  : program-loader FSM states
package nrisc_pkg;

  localparam int LARG_DADO = 8;
  localparam int LARG_END  = 8;

  typedef enum logic [1:0] {
    ESPERA_TAM = 2'd0,  // waiting for the length byte
    CARREGA    = 2'd1,  // storing program bytes
    EXECUTA    = 2'd2   // program loaded, processor running
  } estado_t;

endpackage

// File: rtl/memoria_instrucao.sv
// memoria_instrucao -- PROF x 8 instruction memory.
// Synchronous write, asynchronous (combinational) read, no reset on contents.
//   clock        : write clock, rising edge
//   we           : write enable
//   end_escrita  : write address
//   dado_escrita : write data
//   end_leitura  : read address
//   dado_leitura : read data (same cycle)
module memoria_instrucao
  import nrisc_pkg::*;
#(
  parameter int PROF = 256
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [LARG_END-1:0]  end_escrita,
  input  logic [LARG_DADO-1:0] dado_escrita,
  input  logic [LARG_END-1:0]  end_leitura,
  output logic [LARG_DADO-1:0] dado_leitura
);

  logic [LARG_DADO-1:0] mem [PROF];

  // Addresses beyond a shallower memory are dropped on write and read as 0.
  always_ff @(posedge clock) begin
    if (we && (32'(end_escrita) < PROF)) begin
      mem[end_escrita] <= dado_escrita;
    end
  end

  always_comb begin
    dado_leitura = '0;
    if (32'(end_leitura) < PROF) begin
      dado_leitura = mem[end_leitura];
    end
  end

endmodule

// File: rtl/carregador_programa.sv
// carregador_programa -- loads a length-prefixed program from a byte stream
// into instruction memory, then releases the processor from reset and serves
// instructions to it.
//
// Handshake: a byte moves on a rising edge where byte_valid and byte_ready
// are both 1; byte_valid may be held or dropped freely, byte_ready depends
// only on the FSM state.
//
// Ports:
//   clock, reset   : system clock; asynchronous active-high reset
//   byte_in/valid  : program stream from host (first byte = length, 0 = 256)
//   byte_ready     : 1 while loading, 0 while running
//   recarregar     : in EXECUTA, start a new load at the next edge
//   PC / instr     : processor fetch port (instr is 0 unless running)
//   cpu_reset      : processor reset, held high until the load completes
//   carregado      : a complete program is in memory
//   endereco_carga : next address to be written
module carregador_programa
  import nrisc_pkg::*;
#(
  parameter int PROF = 256
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [LARG_DADO-1:0] byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  input  logic                 recarregar,
  input  logic [LARG_END-1:0]  PC,
  output logic [LARG_DADO-1:0] instr,
  output logic                 cpu_reset,
  output logic                 carregado,
  output logic [LARG_END-1:0]  endereco_carga
);

  estado_t              estado, estado_prox;
  logic [LARG_DADO-1:0] tamanho;
  logic                 transfere;
  logic                 escreve;
  logic                 ultimo;
  logic [LARG_DADO-1:0] dado_lido;

  assign byte_ready = (estado != EXECUTA);
  assign transfere  = byte_valid && byte_ready;
  assign escreve    = (estado == CARREGA) && transfere;
  // Length 0 encodes 256: 0 - 1 wraps to 255, the last address of a full load.
  assign ultimo     = (endereco_carga == (tamanho - 8'd1));

  always_comb begin
    estado_prox = estado;
    case (estado)
      ESPERA_TAM: if (transfere) estado_prox = CARREGA;
      CARREGA:    if (transfere && ultimo) estado_prox = EXECUTA;
      EXECUTA:    if (recarregar) estado_prox = ESPERA_TAM;
      default:    estado_prox = ESPERA_TAM;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado         <= ESPERA_TAM;
      tamanho        <= '0;
      endereco_carga <= '0;
      cpu_reset      <= 1'b1;
      carregado      <= 1'b0;
    end else begin
      estado    <= estado_prox;
      // Both flags follow the state being entered, so they change on the
      // same edge as the transition itself.
      cpu_reset <= (estado_prox != EXECUTA);
      carregado <= (estado_prox == EXECUTA);
      if (estado == ESPERA_TAM && transfere) begin
        tamanho        <= byte_in;
        endereco_carga <= '0;
      end else if (escreve) begin
        endereco_carga <= endereco_carga + 8'd1;
      end
    end
  end

  memoria_instrucao #(.PROF(PROF)) u_mem (
    .clock        (clock),
    .we           (escreve),
    .end_escrita  (endereco_carga),
    .dado_escrita (byte_in),
    .end_leitura  (PC),
    .dado_leitura (dado_lido)
  );

  // Reads are masked while loading, so a same-cycle write never shows up.
  assign instr = (estado == EXECUTA) ? dado_lido : '0;

endmodule
